bram_read_checker: RTL and testbench



---
 rtl/bram_read_checker.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_bram_read_checker.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bram_read_checker.sv
// Purpose: snoops a dual-port BRAM, shadows recent writes and checks each read result against them.
// Latency: a read captured at edge N is compared against q_a/q_b at edge N+1; results are visible after N+1.
// Backpressure: none; this is a passive monitor that accepts every cycle and never stalls the traffic it watches.
module bram_read_checker #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int SHADOW_ENTRIES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic [DATA_WIDTH-1:0] data_b,
  input  logic                  we_a,
  input  logic                  we_b,
  input  logic [DATA_WIDTH-1:0] q_a,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic [15:0]           pass_count,
  output logic [15:0]           fail_count,
  output logic                  err_a,
  output logic                  err_b,
  output logic                  collision,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_got,
  output logic [1:0]            status
);

  localparam int PW = $clog2(SHADOW_ENTRIES);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FAIL = 2'b10
  } state_t;

  // Shadow of recently written locations
  logic [SHADOW_ENTRIES-1:0] r_sh_vld;
  logic [ADDR_WIDTH-1:0]     r_sh_addr [SHADOW_ENTRIES];
  logic [DATA_WIDTH-1:0]     r_sh_data [SHADOW_ENTRIES];
  logic [PW-1:0]             r_wr_ptr;

  logic [SHADOW_ENTRIES-1:0] w_nx_vld;
  logic [ADDR_WIDTH-1:0]     w_nx_addr [SHADOW_ENTRIES];
  logic [DATA_WIDTH-1:0]     w_nx_data [SHADOW_ENTRIES];
  logic [PW-1:0]             w_nx_ptr;
  logic                      w_wa_hit;
  logic [PW-1:0]             w_wa_idx;
  logic                      w_wb_hit;
  logic [PW-1:0]             w_wb_idx;

  // Read lookup and capture
  logic                  w_rd_hit_a;
  logic                  w_rd_hit_b;
  logic [DATA_WIDTH-1:0] w_rd_exp_a;
  logic [DATA_WIDTH-1:0] w_rd_exp_b;
  logic                  w_cap_a;
  logic                  w_cap_b;

  // Stage registers holding one pending check per port
  logic                  r_chk_a;
  logic                  r_chk_b;
  logic [DATA_WIDTH-1:0] r_exp_a;
  logic [DATA_WIDTH-1:0] r_exp_b;
  logic [ADDR_WIDTH-1:0] r_stg_addr_a;
  logic [ADDR_WIDTH-1:0] r_stg_addr_b;

  // Compare results and counters
  logic        w_ok_a;
  logic        w_ok_b;
  logic        w_mis_a;
  logic        w_mis_b;
  logic [16:0] w_pass_sum;
  logic [16:0] w_fail_sum;
  logic [15:0] w_pass_nx;
  logic [15:0] w_fail_nx;

  logic [15:0]           r_pass_cnt;
  logic [15:0]           r_fail_cnt;
  logic                  r_err_a;
  logic                  r_err_b;
  logic                  r_coll;
  logic [ADDR_WIDTH-1:0] r_fail_addr;
  logic [DATA_WIDTH-1:0] r_fail_exp;
  logic [DATA_WIDTH-1:0] r_fail_got;

  state_t r_state;
  state_t w_state_nx;

  // Next shadow contents: port A's write is applied first, then port B's on top of it,
  // so a same-address pair lands in a single entry carrying port B's data.
  always_comb begin
    w_nx_vld  = r_sh_vld;
    w_nx_addr = r_sh_addr;
    w_nx_data = r_sh_data;
    w_nx_ptr  = r_wr_ptr;
    w_wa_hit  = 1'b0;
    w_wa_idx  = '0;
    w_wb_hit  = 1'b0;
    w_wb_idx  = '0;
    if (we_a) begin
      for (int i = 0; i < SHADOW_ENTRIES; i++) begin
        if (w_nx_vld[i] && (w_nx_addr[i] == addr_a)) begin
          w_wa_hit = 1'b1;
          w_wa_idx = PW'(i);
        end
      end
      if (!w_wa_hit) begin
        w_wa_idx = w_nx_ptr;
        w_nx_ptr = w_nx_ptr + PW'(1);
      end
      w_nx_vld[w_wa_idx]  = 1'b1;
      w_nx_addr[w_wa_idx] = addr_a;
      w_nx_data[w_wa_idx] = data_a;
    end
    if (we_b) begin
      for (int i = 0; i < SHADOW_ENTRIES; i++) begin
        if (w_nx_vld[i] && (w_nx_addr[i] == addr_b)) begin
          w_wb_hit = 1'b1;
          w_wb_idx = PW'(i);
        end
      end
      if (!w_wb_hit) begin
        w_wb_idx = w_nx_ptr;
        w_nx_ptr = w_nx_ptr + PW'(1);
      end
      w_nx_vld[w_wb_idx]  = 1'b1;
      w_nx_addr[w_wb_idx] = addr_b;
      w_nx_data[w_wb_idx] = data_b;
    end
  end

  // Shadow storage and round-robin allocation pointer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh_vld <= '0;
      r_wr_ptr <= '0;
      for (int i = 0; i < SHADOW_ENTRIES; i++) begin
        r_sh_addr[i] <= '0;
        r_sh_data[i] <= '0;
      end
    end else begin
      r_sh_vld  <= w_nx_vld;
      r_wr_ptr  <= w_nx_ptr;
      r_sh_addr <= w_nx_addr;
      r_sh_data <= w_nx_data;
    end
  end

  // Read lookup against the shadow as it stood before this cycle's writes
  always_comb begin
    w_rd_hit_a = 1'b0;
    w_rd_hit_b = 1'b0;
    w_rd_exp_a = '0;
    w_rd_exp_b = '0;
    for (int i = 0; i < SHADOW_ENTRIES; i++) begin
      if (r_sh_vld[i] && (r_sh_addr[i] == addr_a)) begin
        w_rd_hit_a = 1'b1;
        w_rd_exp_a = r_sh_data[i];
      end
      if (r_sh_vld[i] && (r_sh_addr[i] == addr_b)) begin
        w_rd_hit_b = 1'b1;
        w_rd_exp_b = r_sh_data[i];
      end
    end
    // A read racing the other port's write to the same address has no defined result.
    w_cap_a = !we_a && w_rd_hit_a && !(we_b && (addr_b == addr_a));
    w_cap_b = !we_b && w_rd_hit_b && !(we_a && (addr_a == addr_b));
  end

  // Stage the expected value for comparison against next cycle's q
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk_a      <= 1'b0;
      r_chk_b      <= 1'b0;
      r_exp_a      <= '0;
      r_exp_b      <= '0;
      r_stg_addr_a <= '0;
      r_stg_addr_b <= '0;
    end else begin
      r_chk_a      <= w_cap_a;
      r_chk_b      <= w_cap_b;
      r_exp_a      <= w_rd_exp_a;
      r_exp_b      <= w_rd_exp_b;
      r_stg_addr_a <= addr_a;
      r_stg_addr_b <= addr_b;
    end
  end

  // Compare staged expectations with returned data and form saturating counts
  always_comb begin
    w_ok_a     = r_chk_a && (q_a == r_exp_a);
    w_ok_b     = r_chk_b && (q_b == r_exp_b);
    w_mis_a    = r_chk_a && (q_a != r_exp_a);
    w_mis_b    = r_chk_b && (q_b != r_exp_b);
    w_pass_sum = {1'b0, r_pass_cnt} + {16'd0, w_ok_a} + {16'd0, w_ok_b};
    w_fail_sum = {1'b0, r_fail_cnt} + {16'd0, w_mis_a} + {16'd0, w_mis_b};
    w_pass_nx  = w_pass_sum[16] ? 16'hFFFF : w_pass_sum[15:0];
    w_fail_nx  = w_fail_sum[16] ? 16'hFFFF : w_fail_sum[15:0];
  end

  // Counters, error pulses, collision flag and last-failure capture (port B wins a tie)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
      r_err_a     <= 1'b0;
      r_err_b     <= 1'b0;
      r_coll      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
    end else begin
      r_pass_cnt <= w_pass_nx;
      r_fail_cnt <= w_fail_nx;
      r_err_a    <= w_mis_a;
      r_err_b    <= w_mis_b;
      if (we_a && we_b && (addr_a == addr_b)) begin
        r_coll <= 1'b1;
      end
      if (w_mis_b) begin
        r_fail_addr <= r_stg_addr_b;
        r_fail_exp  <= r_exp_b;
        r_fail_got  <= q_b;
      end else if (w_mis_a) begin
        r_fail_addr <= r_stg_addr_a;
        r_fail_exp  <= r_exp_a;
        r_fail_got  <= q_a;
      end
    end
  end

  // Status state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Status next state: first write starts the run, first mismatch is sticky
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mis_a || w_mis_b) begin
          w_state_nx = S_FAIL;
        end else if (we_a || we_b) begin
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (w_mis_a || w_mis_b) begin
          w_state_nx = S_FAIL;
        end
      end
      S_FAIL:  w_state_nx = S_FAIL;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Status output decode
  always_comb begin
    status = 2'b00;
    case (r_state)
      S_IDLE:  status = 2'b00;
      S_RUN:   status = 2'b01;
      S_FAIL:  status = 2'b10;
      default: status = 2'b00;
    endcase
  end

  assign pass_count    = r_pass_cnt;
  assign fail_count    = r_fail_cnt;
  assign err_a         = r_err_a;
  assign err_b         = r_err_b;
  assign collision     = r_coll;
  assign fail_addr     = r_fail_addr;
  assign fail_expected = r_fail_exp;
  assign fail_got      = r_fail_got;

endmodule

// File: tb/tb_bram_read_checker.sv
// Purpose: directed bench for bram_read_checker using a vector table plus hand-written sequences.
// Latency: each vector is one clock; outputs are compared 1 time unit after the rising edge.
// Backpressure: not applicable; stimulus is driven every cycle.
module tb_bram_read_checker;

  logic        clk;
  logic        reset;
  logic [9:0]  addr_a, addr_b;
  logic [15:0] data_a, data_b;
  logic        we_a, we_b;
  logic [15:0] q_a, q_b;
  logic [15:0] pass_count, fail_count;
  logic        err_a, err_b, collision;
  logic [9:0]  fail_addr;
  logic [15:0] fail_expected, fail_got;
  logic [1:0]  status;

  int n_checks = 0;
  int n_errors = 0;

  bram_read_checker #(
    .DATA_WIDTH(16),
    .ADDR_WIDTH(10),
    .SHADOW_ENTRIES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .data_a(data_a),
    .data_b(data_b),
    .we_a(we_a),
    .we_b(we_b),
    .q_a(q_a),
    .q_b(q_b),
    .pass_count(pass_count),
    .fail_count(fail_count),
    .err_a(err_a),
    .err_b(err_b),
    .collision(collision),
    .fail_addr(fail_addr),
    .fail_expected(fail_expected),
    .fail_got(fail_got),
    .status(status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wa, wb;
    logic [9:0]  aa, ab;
    logic [15:0] da, db, qa, qb;
    logic [15:0] e_pass, e_fail;
    logic        e_ea, e_eb, e_coll;
    logic [1:0]  e_st;
    logic [9:0]  e_faddr;
    logic [15:0] e_fexp, e_fgot;
  } vec_t;

  function automatic vec_t mk(input logic wa, input logic wb, input int aa, input int ab,
                              input int da, input int db, input int qa, input int qb,
                              input int ep, input int ef, input logic ea, input logic eb,
                              input logic ec, input int est, input int efa, input int efe,
                              input int efg);
    vec_t v;
    v.wa = wa; v.wb = wb; v.aa = 10'(aa); v.ab = 10'(ab);
    v.da = 16'(da); v.db = 16'(db); v.qa = 16'(qa); v.qb = 16'(qb);
    v.e_pass = 16'(ep); v.e_fail = 16'(ef); v.e_ea = ea; v.e_eb = eb; v.e_coll = ec;
    v.e_st = 2'(est); v.e_faddr = 10'(efa); v.e_fexp = 16'(efe); v.e_fgot = 16'(efg);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic wa, input logic wb, input logic [9:0] aa, input logic [9:0] ab,
                     input logic [15:0] da, input logic [15:0] db,
                     input logic [15:0] qa, input logic [15:0] qb);
    we_a = wa; we_b = wb; addr_a = aa; addr_b = ab;
    data_a = da; data_b = db; q_a = qa; q_b = qb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int ep, input int ef, input logic ea,
                         input logic eb, input int est);
    chk({tag, " pass_count"}, 32'(pass_count), 32'(ep));
    chk({tag, " fail_count"}, 32'(fail_count), 32'(ef));
    chk({tag, " err_a"}, 32'(err_a), 32'(ea));
    chk({tag, " err_b"}, 32'(err_b), 32'(eb));
    chk({tag, " status"}, 32'(status), 32'(est));
  endtask

  vec_t vt[18];

  initial begin
    // Idle reads use addresses 100/101, which are never written in the table.
    vt[0]  = mk(1, 1,   0,   1,  8, 10,  0,  0,  0, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[1]  = mk(0, 0,   0,   1,  0,  0,  0,  0,  0, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[2]  = mk(0, 0, 100, 101,  0,  0,  8, 10,  2, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[3]  = mk(1, 1,   0,   1,  9, 11,  0,  0,  2, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[4]  = mk(1, 1, 510, 511, 32, 18,  0,  0,  2, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[5]  = mk(0, 0,   0,   1,  0,  0,  0,  0,  2, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[6]  = mk(0, 0, 510, 511,  0,  0,  9, 11,  4, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[7]  = mk(0, 0, 100, 101,  0,  0, 32, 18,  6, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[8]  = mk(0, 0,   0, 100,  0,  0,  0,  0,  6, 0, 0, 0, 0, 1, 0,  0, 0);
    vt[9]  = mk(0, 0,   1, 101,  0,  0,  7,  0,  6, 1, 1, 0, 0, 2, 0,  9, 7);
    vt[10] = mk(0, 0, 100, 101,  0,  0, 11,  0,  7, 1, 0, 0, 0, 2, 0,  9, 7);
    vt[11] = mk(1, 1,   5,   5,  1,  2,  0,  0,  7, 1, 0, 0, 1, 2, 0,  9, 7);
    vt[12] = mk(0, 0,   5, 100,  0,  0,  0,  0,  7, 1, 0, 0, 1, 2, 0,  9, 7);
    vt[13] = mk(0, 0,   5, 100,  0,  0,  2,  0,  8, 1, 0, 0, 1, 2, 0,  9, 7);
    vt[14] = mk(0, 0, 100, 101,  0,  0,  1,  0,  8, 2, 1, 0, 1, 2, 5,  2, 1);
    vt[15] = mk(0, 0,   0,   1,  0,  0,  0,  0,  8, 2, 0, 0, 1, 2, 5,  2, 1);
    vt[16] = mk(0, 0, 100, 101,  0,  0,  1,  2,  8, 4, 1, 1, 1, 2, 1, 11, 2);
    vt[17] = mk(0, 0, 100, 101,  0,  0,  0,  0,  8, 4, 0, 0, 1, 2, 1, 11, 2);

    reset = 1'b0;
    we_a = 0; we_b = 0; addr_a = 10'd100; addr_b = 10'd101;
    data_a = '0; data_b = '0; q_a = '0; q_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    chk("reset collision", 32'(collision), 0);
    chk("reset fail_addr", 32'(fail_addr), 0);
    chk("reset fail_expected", 32'(fail_expected), 0);
    chk("reset fail_got", 32'(fail_got), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      cyc(vt[i].wa, vt[i].wb, vt[i].aa, vt[i].ab, vt[i].da, vt[i].db, vt[i].qa, vt[i].qb);
      chk_all(tag, 32'(vt[i].e_pass), 32'(vt[i].e_fail), vt[i].e_ea, vt[i].e_eb, 32'(vt[i].e_st));
      chk({tag, " collision"}, 32'(collision), 32'(vt[i].e_coll));
      chk({tag, " fail_addr"}, 32'(fail_addr), 32'(vt[i].e_faddr));
      chk({tag, " fail_expected"}, 32'(fail_expected), 32'(vt[i].e_fexp));
      chk({tag, " fail_got"}, 32'(fail_got), 32'(vt[i].e_fgot));
    end

    // Reset while reads of 0/1 are pending; the wrong q must never be counted.
    cyc(0, 0, 10'd0, 10'd1, 0, 0, 0, 0);
    q_a = 16'h1234; q_b = 16'h1234;
    addr_a = 10'd100; addr_b = 10'd101;
    #2;
    reset = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0);
    chk("rst_async collision", 32'(collision), 0);
    chk("rst_async fail_got", 32'(fail_got), 0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    cyc(0, 0, 10'd100, 10'd101, 0, 0, 16'h1234, 16'h1234);
    chk_all("rst_after", 0, 0, 0, 0, 0);

    // Nine distinct writes into an 8-entry shadow evict address 0.
    for (int i = 0; i < 9; i++) begin
      cyc(1, 0, 10'(i), 10'd100, 16'(100 + i), 0, 0, 0);
    end
    chk("evict status", 32'(status), 1);
    cyc(0, 0, 10'd0, 10'd101, 0, 0, 0, 0);
    cyc(0, 0, 10'd8, 10'd1, 0, 0, 16'hDEAD, 16'hDEAD);
    chk_all("evict read0", 0, 0, 0, 0, 1);
    cyc(0, 0, 10'd100, 10'd101, 0, 0, 16'd108, 16'd101);
    chk_all("evict read8", 2, 0, 0, 0, 1);

    // Port A reads 3 while port B writes 3: unchecked; the new value is visible next cycle.
    cyc(0, 1, 10'd3, 10'd3, 0, 16'd55, 0, 0);
    cyc(0, 0, 10'd3, 10'd100, 0, 0, 16'hBEEF, 0);
    chk_all("rdw skip", 2, 0, 0, 0, 1);
    cyc(0, 0, 10'd100, 10'd101, 0, 0, 16'd55, 0);
    chk_all("rdw next", 3, 0, 0, 0, 1);

    // A write cycle on a shadowed address is never checked.
    cyc(1, 0, 10'd2, 10'd100, 16'd77, 0, 0, 0);
    cyc(0, 0, 10'd100, 10'd101, 0, 0, 16'h0BAD, 16'h0BAD);
    chk_all("write nochk", 3, 0, 0, 0, 1);

    // Saturation: both ports read address 8 correctly until the pass count clamps.
    we_a = 0; we_b = 0; addr_a = 10'd8; addr_b = 10'd8; q_a = 16'd108; q_b = 16'd108;
    repeat (32770) @(posedge clk);
    #1;
    chk_all("saturate", 16'hFFFF, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
